// File: rtl/branch_target_predictor.sv
// rtl/branch_target_predictor.sv - direct-mapped BTB with 2-bit counters, EX-stage resolution and stats
module branch_target_predictor #(
  parameter int ENTRIES = 64,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      PCF,
  output logic             PredTakenF,
  output logic [31:0]      PredTargetF,
  input  logic             UpdateE,
  input  logic [31:0]      PCE,
  input  logic             BranchE,
  input  logic [31:0]      BranchTargetE,
  input  logic             PredTakenE,
  input  logic [31:0]      PredTargetE,
  output logic             MispredE,
  output logic [31:0]      CorrectPCE,
  output logic [CNT_W-1:0] BranchCnt,
  output logic [CNT_W-1:0] MispredCnt
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 32 - IDX_W - 2;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  logic [ENTRIES-1:0]       valid_q, valid_d;
  logic [ENTRIES-1:0][1:0]  ctr_q, ctr_d;
  logic [TAG_W-1:0]         tag_q    [ENTRIES];
  logic [TAG_W-1:0]         tag_d    [ENTRIES];
  logic [31:0]              target_q [ENTRIES];
  logic [31:0]              target_d [ENTRIES];
  logic [CNT_W-1:0]         branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0]         mispred_cnt_q, mispred_cnt_d;

  logic [IDX_W-1:0] idx_f, idx_e;
  logic [TAG_W-1:0] tag_f, tag_e;
  logic             hit_f, hit_e;

  function automatic logic [1:0] ctr_next(input logic [1:0] c, input logic taken);
    logic [1:0] n;
    n = c;
    if (taken && c != CTR_ST) begin
      n = c + 2'd1;
    end else if (!taken && c != CTR_SNT) begin
      n = c - 2'd1;
    end
    return n;
  endfunction

  assign idx_f = PCF[IDX_W+1:2];
  assign tag_f = PCF[31:IDX_W+2];
  assign idx_e = PCE[IDX_W+1:2];
  assign tag_e = PCE[31:IDX_W+2];

  // Lookup reads the registered arrays only, so a same-cycle update stays invisible until next cycle.
  always_comb begin
    hit_f       = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
    PredTakenF  = hit_f && ctr_q[idx_f][1];
    PredTargetF = PredTakenF ? target_q[idx_f] : PCF + 32'd4;
  end

  always_comb begin
    hit_e      = valid_q[idx_e] && (tag_q[idx_e] == tag_e);
    MispredE   = UpdateE && ((BranchE != PredTakenE) ||
                             (BranchE && (PredTargetE != BranchTargetE)));
    CorrectPCE = '0;
    if (UpdateE) begin
      CorrectPCE = BranchE ? BranchTargetE : PCE + 32'd4;
    end
  end

  always_comb begin
    valid_d  = valid_q;
    ctr_d    = ctr_q;
    tag_d    = tag_q;
    target_d = target_q;
    if (UpdateE) begin
      if (hit_e) begin
        ctr_d[idx_e] = ctr_next(ctr_q[idx_e], BranchE);
        if (BranchE) begin
          target_d[idx_e] = BranchTargetE;
        end
      end else if (BranchE) begin
        // A taken miss claims the slot even if another tag lives there.
        valid_d[idx_e]  = 1'b1;
        tag_d[idx_e]    = tag_e;
        target_d[idx_e] = BranchTargetE;
        ctr_d[idx_e]    = CTR_WT;
      end
    end
  end

  always_comb begin
    branch_cnt_d  = branch_cnt_q + {{(CNT_W-1){1'b0}}, UpdateE};
    mispred_cnt_d = mispred_cnt_q + {{(CNT_W-1){1'b0}}, MispredE};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q       <= '0;
      ctr_q         <= {ENTRIES{CTR_WNT}};
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      valid_q       <= valid_d;
      ctr_q         <= ctr_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  // Tag and target contents are qualified by valid, so they carry no reset.
  always_ff @(posedge clk) begin
    tag_q    <= tag_d;
    target_q <= target_d;
  end

  assign BranchCnt  = branch_cnt_q;
  assign MispredCnt = mispred_cnt_q;

endmodule
